// File: rtl/rr_mux_sel_arbiter_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
// Consumed by the interface, the pick sub-module and the top level.
package rr_arb_pkg;

    localparam int N_SRC = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_t;

    function automatic logic [N_SRC-1:0] onehot4(input logic [SEL_W-1:0] sel);
        return N_SRC'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_mux_sel_arbiter_if.sv
// Request/select bundle between the four sources, the arbiter and the 4:1 mux.
// xfer_count exists only when RR_XFER_COUNT_EN is defined.
interface rr_mux_sel_arbiter_if;
    import rr_arb_pkg::*;

    logic [N_SRC-1:0] req;
    logic             out_ready;
    logic [SEL_W-1:0] sel;
    logic [N_SRC-1:0] grant;
    logic             gnt_valid;
    logic [N_SRC-1:0] done;
    logic             timeout;
`ifdef RR_XFER_COUNT_EN
    logic [15:0]      xfer_count;

    modport master (
        output req, out_ready,
        input  sel, grant, gnt_valid, done, timeout, xfer_count
    );

    modport slave (
        input  req, out_ready,
        output sel, grant, gnt_valid, done, timeout, xfer_count
    );
`else
    modport master (
        output req, out_ready,
        input  sel, grant, gnt_valid, done, timeout
    );

    modport slave (
        input  req, out_ready,
        output sel, grant, gnt_valid, done, timeout
    );
`endif

endinterface

// File: rtl/rr_mux_sel_arbiter_pick4.sv
// Combinational round-robin pick: first set request bit at ptr, ptr+1, ... (mod 4).
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             found
);

    always_comb begin
        logic [SEL_W-1:0] idx;
        // NOTE: every output is given a default before any branch so no path infers a latch.
        pick  = ptr;
        found = 1'b0;
        idx   = '0;
        // Scan from farthest to nearest so the closest-to-ptr hit is written last and wins.
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of the downstream 4:1 mux.
// Optional accepted-transfer counter enabled by RR_XFER_COUNT_EN.
module rr_mux_sel_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_mux_sel_arbiter_if.slave  bus
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [SEL_W-1:0] idle_pick, rearb_pick, next_ptr;
    logic             idle_found, rearb_found;
    logic [N_SRC-1:0] rearb_req;
    logic             xfer, expire, release_now;

    assign next_ptr  = sel_q + SEL_W'(1);
    assign rearb_req = bus.req & ~onehot4(sel_q);

    rr_pick4 u_pick_idle (
        .req   (bus.req),
        .ptr   (ptr_q),
        .pick  (idle_pick),
        .found (idle_found)
    );

    // Re-arbitration already sees the advanced pointer and excludes the source just served.
    rr_pick4 u_pick_rearb (
        .req   (rearb_req),
        .ptr   (next_ptr),
        .pick  (rearb_pick),
        .found (rearb_found)
    );

    assign xfer        = (state_q == ST_GRANT) && bus.out_ready;
    assign expire      = (MAX_HOLD > 0) && (state_q == ST_GRANT) && !bus.out_ready
                         && (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign release_now = xfer || expire;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (idle_found) begin
                    sel_d   = idle_pick;
                    grant_d = onehot4(idle_pick);
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    ptr_d     = next_ptr;
                    timeout_d = expire;
                    hold_d    = '0;
                    if (rearb_found) begin
                        sel_d   = rearb_pick;
                        grant_d = onehot4(rearb_pick);
                        valid_d = 1'b1;
                    end else begin
                        grant_d = '0;
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (MAX_HOLD > 0) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous, so it is just the first branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.done      = grant_q & {N_SRC{valid_q & bus.out_ready}};

`ifdef RR_XFER_COUNT_EN
    logic [15:0] xfer_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count_q <= '0;
        end else if (xfer) begin
            xfer_count_q <= xfer_count_q + 16'd1;
        end
    end

    assign bus.xfer_count = xfer_count_q;
`endif

endmodule
